// File: rtl/isqrt_share_arb_if.sv
// Requester, response and isqrt-side signals of the shared isqrt arbiter.
// slave is the arbiter side; master is the requester/isqrt side.
interface isqrt_share_arb_if #(
  parameter int N = 3
);
  logic [N-1:0]    req_vld;
  logic [N*32-1:0] req_x;
  logic [N-1:0]    req_rdy;
  logic [N-1:0]    rsp_vld;
  logic [31:0]     rsp_y;
  logic            sq_x_vld;
  logic [31:0]     sq_x;
  logic            sq_y_vld;
  logic [31:0]     sq_y;
  logic            err;

  modport slave (
    input  req_vld, req_x, sq_y_vld, sq_y,
    output req_rdy, rsp_vld, rsp_y, sq_x_vld, sq_x, err
  );

  modport master (
    output req_vld, req_x, sq_y_vld, sq_y,
    input  req_rdy, rsp_vld, rsp_y, sq_x_vld, sq_x, err
  );
endinterface

// File: rtl/isqrt_share_arb.sv
// Round-robin time-sharing of one pipelined isqrt among N requesters; a tag
// pipe travelling alongside the isqrt routes each result back to its issuer.
module isqrt_share_arb #(
  parameter int  N       = 3,
  parameter int  LATENCY = 16,
  localparam int TW      = $clog2(N)
) (
  input logic              clk,
  input logic              rst,
  isqrt_share_arb_if.slave bus
);
  // Stage 0 rides with sq_x; stage LATENCY lines up with sq_y_vld.
  localparam int           DEPTH    = LATENCY + 1;
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [TW-1:0]    ptr_r;
  logic [TW-1:0]    gnt_idx_s;
  logic             gnt_any_s;
  logic [N-1:0]     gnt_s;
  logic [31:0]      x_sel_s;
  logic             sq_x_vld_r;
  logic [31:0]      sq_x_r;
  logic [DEPTH-1:0] tag_vld_r;
  logic [TW-1:0]    tag_r [DEPTH];
  logic             rsp_hit_s;
  logic [N-1:0]     rsp_vld_r;
  logic [31:0]      rsp_y_r;
  logic             err_r;

  // Round-robin search starting just after the last granted requester
  always_comb begin : grant_search
    logic [TW-1:0] cand;
    logic          hit;
    cand      = '0;
    hit       = 1'b0;
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    for (int off = 1; off <= N; off++) begin
      cand      = TW'((int'(ptr_r) + off) % N);
      hit       = ~gnt_any_s & bus.req_vld[cand] & ~rst;
      gnt_idx_s = hit ? cand : gnt_idx_s;
      gnt_any_s = gnt_any_s | hit;
    end
    gnt_s = gnt_any_s ? (ONE_HOT0 << gnt_idx_s) : '0;
  end

  // Argument select for the granted requester
  always_comb begin
    x_sel_s = '0;
    for (int i = 0; i < N; i++) begin
      x_sel_s = x_sel_s | ({32{gnt_s[i]}} & bus.req_x[i*32 +: 32]);
    end
  end

  // Issue register and pointer; sq_x holds when idle to avoid toggling
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= TW'(N - 1);
      sq_x_vld_r <= 1'b0;
      sq_x_r     <= 32'd0;
    end else begin
      sq_x_vld_r <= gnt_any_s;
      if (gnt_any_s) begin
        ptr_r  <= gnt_idx_s;
        sq_x_r <= x_sel_s;
      end
    end
  end

  // Tag-pipe valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_r <= '0;
    end else begin
      tag_vld_r <= {tag_vld_r[DEPTH-2:0], gnt_any_s};
    end
  end

  // Tag-pipe data, loaded only behind a valid entry
  always_ff @(posedge clk) begin
    if (gnt_any_s) begin
      tag_r[0] <= gnt_idx_s;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (tag_vld_r[k-1]) begin
        tag_r[k] <= tag_r[k-1];
      end
    end
  end

  assign rsp_hit_s = bus.sq_y_vld & tag_vld_r[LATENCY];

  // Response routing and sticky latency-mismatch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_r <= '0;
      rsp_y_r   <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      rsp_vld_r <= rsp_hit_s ? (ONE_HOT0 << tag_r[LATENCY]) : '0;
      if (rsp_hit_s) begin
        rsp_y_r <= bus.sq_y;
      end
      if (bus.sq_y_vld != tag_vld_r[LATENCY]) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.req_rdy  = gnt_s;
  assign bus.sq_x_vld = sq_x_vld_r;
  assign bus.sq_x     = sq_x_r;
  assign bus.rsp_vld  = rsp_vld_r;
  assign bus.rsp_y    = rsp_y_r;
  assign bus.err      = err_r;
endmodule

// File: tb/tb_isqrt_share_arb.sv
// Scoreboard bench for isqrt_share_arb with a behavioural fixed-latency isqrt.
module tb_isqrt_share_arb;
  localparam int N       = 3;
  localparam int LATENCY = 16;
  localparam int RSP_LAT = LATENCY + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inj = 1'b0;
  logic [N-1:0] en  = '0;
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           rsp_cnt = 0;

  logic [31:0] pend_x [N][$];
  logic [31:0] pend_y [N][$];
  logic [31:0] exp_y  [N][$];
  int          exp_t  [N][$];
  int          glog_id [$];
  int          glog_cyc [$];
  int          waitc [N];

  isqrt_share_arb_if #(.N(N)) bus ();

  isqrt_share_arb #(.N(N), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] isqrt32(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[31:0];
  endfunction

  // Behavioural isqrt: y_vld exactly LATENCY cycles after x_vld
  logic [LATENCY-1:0] m_vld;
  logic [31:0]        m_y [LATENCY];
  always @(posedge clk) begin
    if (rst) m_vld <= '0;
    else     m_vld <= {m_vld[LATENCY-2:0], bus.sq_x_vld};
    m_y[0] <= isqrt32(bus.sq_x);
    for (int k = 1; k < LATENCY; k++) m_y[k] <= m_y[k-1];
  end
  assign bus.sq_y_vld = m_vld[LATENCY-1] | inj;
  assign bus.sq_y     = m_y[LATENCY-1];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int outstanding();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend_x[i].size() + exp_y[i].size();
    return s;
  endfunction

  // Requesters: present queued arguments, push expectations on each transfer
  initial begin : driver
    logic [N-1:0] fired;
    fired = '0;
    bus.req_vld = '0;
    bus.req_x   = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        fired[i] = bus.req_vld[i] & bus.req_rdy[i];
        if (fired[i]) begin
          exp_y[i].push_back(pend_y[i][0]);
          exp_t[i].push_back(cyc);
          glog_id.push_back(i);
          glog_cyc.push_back(cyc);
          check($sformatf("fair_wait_rq%0d", i), (waitc[i] < N) ? 0 : waitc[i], 0);
          waitc[i] = 0;
        end else if (bus.req_vld[i] && !rst) begin
          waitc[i]++;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fired[i]) begin
          void'(pend_x[i].pop_front());
          void'(pend_y[i].pop_front());
        end
        if (en[i] && pend_x[i].size() > 0) begin
          bus.req_vld[i]         = 1'b1;
          bus.req_x[i*32 +: 32] = pend_x[i][0];
        end else begin
          bus.req_vld[i] = 1'b0;
        end
      end
    end
  end

  // Response monitor: pop and compare whenever a result pulse appears
  initial begin : monitor
    logic [31:0] y;
    int          t;
    forever begin
      @(negedge clk);
      if (bus.rsp_vld != '0) begin
        rsp_cnt++;
        check("rsp_onehot", $countones(bus.rsp_vld), 1);
        for (int i = 0; i < N; i++) begin
          if (bus.rsp_vld[i]) begin
            if (exp_y[i].size() == 0) begin
              check($sformatf("rsp_unexpected_rq%0d", i), bus.rsp_vld, 0);
            end else begin
              y = exp_y[i].pop_front();
              t = exp_t[i].pop_front();
              check($sformatf("rsp_y_rq%0d", i), bus.rsp_y, y);
              check($sformatf("rsp_latency_rq%0d", i), cyc - t, RSP_LAT);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick_p();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [31:0] x, input logic [31:0] y, input int n);
    for (int k = 0; k < n; k++) begin
      pend_x[r].push_back(x);
      pend_y[r].push_back(y);
    end
  endtask

  task automatic flush_exp();
    for (int i = 0; i < N; i++) begin
      exp_y[i].delete();
      exp_t[i].delete();
    end
  endtask

  task automatic do_reset();
    tick_p();
    rst = 1'b1;
    flush_exp();
    tick_p();
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (outstanding() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, outstanding(), 0);
    en = '0;
  endtask

  logic [31:0] t3x [10] = '{32'd1, 32'd4, 32'd9, 32'd16, 32'd25,
                            32'd36, 32'd49, 32'd64, 32'd81, 32'd100};
  logic [31:0] t3y [10] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
                            32'd6, 32'd7, 32'd8, 32'd9, 32'd10};

  initial begin : main
    int r0;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sq_x_vld", bus.sq_x_vld, 0);
    check("rst_sq_x", bus.sq_x, 0);
    check("rst_rsp_vld", bus.rsp_vld, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    check("rst_err", bus.err, 0);
    check("rst_req_rdy", bus.req_rdy, 0);
    tick_p();
    rst = 1'b0;

    // Lone requester 0
    push(0, 32'd144, 32'd12, 1);
    en = 3'b001;
    @(posedge clk);
    @(negedge clk);
    check("t1_rdy_same_cycle", bus.req_rdy, 3'b001);
    @(negedge clk);
    check("t1_sq_x_vld", bus.sq_x_vld, 1);
    check("t1_sq_x", bus.sq_x, 144);
    @(negedge clk);
    check("t1_sq_x_vld_idle", bus.sq_x_vld, 0);
    check("t1_sq_x_hold", bus.sq_x, 144);
    drain("t1_drain");

    // All three requesters held valid for nine grants
    do_reset();
    glog_id.delete();
    glog_cyc.delete();
    r0 = rsp_cnt;
    push(0, 32'd4, 32'd2, 3);
    push(1, 32'd9, 32'd3, 3);
    push(2, 32'd16, 32'd4, 3);
    en = 3'b111;
    drain("t2_drain");
    check("t2_grant_count", glog_id.size(), 9);
    for (int j = 0; j < glog_id.size(); j++) begin
      check($sformatf("t2_grant_id%0d", j), glog_id[j], j % 3);
      check($sformatf("t2_grant_cyc%0d", j), glog_cyc[j] - glog_cyc[0], j);
    end
    check("t2_rsp_count", rsp_cnt - r0, 9);

    // Requester 1 streaming squares back to back
    glog_id.delete();
    glog_cyc.delete();
    for (int j = 0; j < 10; j++) push(1, t3x[j], t3y[j], 1);
    en = 3'b010;
    drain("t3_drain");
    check("t3_grant_count", glog_id.size(), 10);
    for (int j = 0; j < glog_id.size(); j++) begin
      check($sformatf("t3_grant_id%0d", j), glog_id[j], 1);
      check($sformatf("t3_grant_cyc%0d", j), glog_cyc[j] - glog_cyc[0], j);
    end

    // Requesters 0 and 2 streaming, requester 1 joins late
    glog_id.delete();
    glog_cyc.delete();
    push(0, 32'd25, 32'd5, 12);
    push(2, 32'd49, 32'd7, 12);
    en = 3'b101;
    repeat (5) tick_p();
    push(1, 32'd64, 32'd8, 4);
    en = 3'b111;
    drain("t4_drain");
    n = 0;
    foreach (glog_id[j]) if (glog_id[j] == 1) n++;
    check("t4_rq1_grants", n, 4);

    // Reset with five issues in flight
    push(1, 32'd36, 32'd6, 5);
    en = 3'b010;
    n = 0;
    while (pend_x[1].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_issued", pend_x[1].size(), 0);
    en = '0;
    do_reset();
    r0 = rsp_cnt;
    repeat (30) @(negedge clk);
    check("t5_no_rsp_after_rst", rsp_cnt - r0, 0);

    // Arbitration restarts from requester 0 after reset
    tick_p();
    rst = 1'b1;
    flush_exp();
    push(0, 32'd81, 32'd9, 1);
    push(1, 32'd100, 32'd10, 1);
    push(2, 32'd121, 32'd11, 1);
    en = 3'b111;
    @(posedge clk);
    @(negedge clk);
    check("t5_vld_in_rst", bus.req_vld, 3'b111);
    check("t5_rdy_in_rst", bus.req_rdy, 0);
    tick_p();
    rst = 1'b0;
    @(negedge clk);
    check("t5_first_grant", bus.req_rdy, 3'b001);
    drain("t5_drain");

    // Spurious sq_y_vld with nothing in flight
    r0 = rsp_cnt;
    tick_p();
    inj = 1'b1;
    tick_p();
    inj = 1'b0;
    @(negedge clk);
    check("t6_err_set", bus.err, 1);
    repeat (5) @(negedge clk);
    check("t6_err_sticky", bus.err, 1);
    check("t6_no_rsp", rsp_cnt - r0, 0);
    do_reset();
    @(negedge clk);
    check("t6_err_cleared", bus.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
